decoder_pipe_n: RTL and testbench

//   Parametrised, pipelined one-hot decoder with valid tracking and a sticky accumulator.

---
 rtl/decoder_pipe_n_if.sv | 27 ++
 rtl/decoder_pipe_n.sv | 129 ++++++++++++
 tb/tb_decoder_pipe_n.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/decoder_pipe_n_if.sv
// Bus interface for decoder_pipe_n: pipeline control, index input and decoded outputs.
// Optional range_err output exists only when DECODER_RANGE_CHECK_EN is defined.
interface decoder_pipe_n_if #(
  parameter int SIZE = 8,
  parameter int EW   = (SIZE > 1) ? $clog2(SIZE) : 1
);
  logic            enable;
  logic            in_valid;
  logic [EW-1:0]   encoded;
  logic            clear;
  logic            out_valid;
  logic [SIZE-1:0] decoded;
  logic [SIZE-1:0] sticky;
`ifdef DECODER_RANGE_CHECK_EN
  logic            range_err;

  modport master (output enable, in_valid, encoded, clear,
                  input  out_valid, decoded, sticky, range_err);
  modport slave  (input  enable, in_valid, encoded, clear,
                  output out_valid, decoded, sticky, range_err);
`else
  modport master (output enable, in_valid, encoded, clear,
                  input  out_valid, decoded, sticky);
  modport slave  (input  enable, in_valid, encoded, clear,
                  output out_valid, decoded, sticky);
`endif
endinterface

// File: rtl/decoder_pipe_n.sv
// Pipelined one-hot decoder with valid tracking and a sticky OR-accumulator.
// LATENCY register stages from capture to decoded/out_valid; the last stage is the
// decode register itself. Out-of-range indices decode to all-zero.
// Optional feature: DECODER_RANGE_CHECK_EN adds a registered range_err flag.
module decoder_pipe_n #(
  parameter int SIZE    = 8,
  parameter int LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  decoder_pipe_n_if.slave   bus
);

  localparam int EW = (SIZE > 1) ? $clog2(SIZE) : 1;

  // Entry presented to the output stage this cycle
  logic          fin_valid;
  logic [EW-1:0] fin_index;

  generate
    if (LATENCY == 1) begin : g_direct
      assign fin_valid = bus.in_valid;
      assign fin_index = bus.encoded;
    end else begin : g_pipe
      logic [LATENCY-2:0]         vld_q, vld_d;
      logic [LATENCY-2:0][EW-1:0] idx_q, idx_d;

      // Shift the {valid, index} stages forward when enabled, hold otherwise
      always_comb begin
        vld_d = vld_q;
        idx_d = idx_q;
        if (bus.enable) begin
          vld_d[0] = bus.in_valid;
          idx_d[0] = bus.encoded;
          for (int i = 1; i < LATENCY - 1; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
          end
        end
      end

      // Stage registers; reset drops anything in flight
      always_ff @(posedge clock) begin
        if (reset) begin
          vld_q <= '0;
          idx_q <= '0;
        end else begin
          vld_q <= vld_d;
          idx_q <= idx_d;
        end
      end

      assign fin_valid = vld_q[LATENCY-2];
      assign fin_index = idx_q[LATENCY-2];
    end
  endgenerate

  logic [SIZE-1:0] dec_new;
  logic            out_valid_q, out_valid_d;
  logic [SIZE-1:0] decoded_q, decoded_d;
  logic [SIZE-1:0] sticky_q, sticky_d;

  // Decode the final-stage entry; indices >= SIZE match no bit
  always_comb begin
    dec_new = '0;
    for (int i = 0; i < SIZE; i++) begin
      dec_new[i] = fin_valid && (fin_index == EW'(i));
    end
  end

  // Output stage and sticky next-state; clear wins over accumulation, then the new result is set
  always_comb begin
    out_valid_d = out_valid_q;
    decoded_d   = decoded_q;
    sticky_d    = sticky_q;
    if (bus.enable) begin
      out_valid_d = fin_valid;
      decoded_d   = dec_new;
    end
    if (bus.clear) begin
      sticky_d = bus.enable ? dec_new : '0;
    end else if (bus.enable) begin
      sticky_d = sticky_q | dec_new;
    end
  end

  // Output and sticky registers
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      decoded_q   <= '0;
      sticky_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      decoded_q   <= decoded_d;
      sticky_q    <= sticky_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.decoded   = decoded_q;
  assign bus.sticky    = sticky_q;

`ifdef DECODER_RANGE_CHECK_EN
  localparam logic [EW:0] SIZE_W = (EW + 1)'(SIZE);

  logic range_err_q, range_err_d;

  // Flag a valid final-stage index that falls outside the decoded range; hold under stall
  always_comb begin
    range_err_d = range_err_q;
    if (bus.enable) begin
      range_err_d = fin_valid && ({1'b0, fin_index} >= SIZE_W);
    end
  end

  // range_err register, aligned with out_valid
  always_ff @(posedge clock) begin
    if (reset) begin
      range_err_q <= 1'b0;
    end else begin
      range_err_q <= range_err_d;
    end
  end

  assign bus.range_err = range_err_q;
`endif

endmodule

// File: tb/tb_decoder_pipe_n.sv
// Directed bench for decoder_pipe_n: a vector table on a SIZE=6/LATENCY=1 instance and
// hand-written multi-cycle sequences on a SIZE=8/LATENCY=3 instance.
module tb_decoder_pipe_n;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_a, reset_b;
  int   checks   = 0;
  int   failures = 0;
  int   step_a   = 0;

  decoder_pipe_n_if #(.SIZE(8)) if_a();
  decoder_pipe_n_if #(.SIZE(6)) if_b();

  decoder_pipe_n #(.SIZE(8), .LATENCY(3)) u_a (.clock(clock), .reset(reset_a), .bus(if_a));
  decoder_pipe_n #(.SIZE(6), .LATENCY(1)) u_b (.clock(clock), .reset(reset_b), .bus(if_b));

  typedef struct {
    logic       rst;
    logic       en;
    logic       iv;
    logic [2:0] enc;
    logic       clr;
    logic       ov;
    logic [5:0] dec;
    logic [5:0] st;
    logic       rerr;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rst, en, iv, input logic [2:0] enc, input logic clr,
                         input logic ov, input logic [5:0] dec, st, input logic rerr);
    vec_t v;
    v.rst = rst; v.en = en; v.iv = iv; v.enc = enc; v.clr = clr;
    v.ov = ov; v.dec = dec; v.st = st; v.rerr = rerr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic a_cycle(input string nm, input logic rst, en, iv, input logic [2:0] enc,
                         input logic clr, input logic ov, input logic [7:0] dec, st);
    reset_a       = rst;
    if_a.enable   = en;
    if_a.in_valid = iv;
    if_a.encoded  = enc;
    if_a.clear    = clr;
    @(posedge clock);
    #1;
    step_a++;
    check({nm, "_ov"},  step_a, 32'(if_a.out_valid), 32'(ov));
    check({nm, "_dec"}, step_a, 32'(if_a.decoded),   32'(dec));
    check({nm, "_st"},  step_a, 32'(if_a.sticky),    32'(st));
`ifdef DECODER_RANGE_CHECK_EN
    check({nm, "_rerr"}, step_a, 32'(if_a.range_err), 32'(0));
`endif
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    if_a.enable = 1'b0; if_a.in_valid = 1'b0; if_a.encoded = '0; if_a.clear = 1'b0;
    if_b.enable = 1'b0; if_b.in_valid = 1'b0; if_b.encoded = '0; if_b.clear = 1'b0;

    //       rst en iv enc clr | ov dec    st     rerr
    add_vec(1, 1, 0, 0, 0,   0, 6'h00, 6'h00, 0);
    add_vec(0, 1, 1, 5, 0,   1, 6'h20, 6'h20, 0);
    add_vec(0, 1, 0, 5, 0,   0, 6'h00, 6'h20, 0);
    add_vec(0, 1, 1, 0, 0,   1, 6'h01, 6'h21, 0);
    add_vec(0, 1, 1, 0, 0,   1, 6'h01, 6'h21, 0);
    add_vec(0, 1, 1, 2, 0,   1, 6'h04, 6'h25, 0);
    add_vec(0, 0, 1, 3, 0,   1, 6'h04, 6'h25, 0);
    add_vec(0, 0, 0, 0, 1,   1, 6'h04, 6'h00, 0);
    add_vec(0, 1, 1, 1, 0,   1, 6'h02, 6'h02, 0);
    add_vec(0, 1, 1, 7, 0,   1, 6'h00, 6'h02, 1);
    add_vec(0, 0, 0, 0, 0,   1, 6'h00, 6'h02, 1);
    add_vec(0, 1, 1, 6, 0,   1, 6'h00, 6'h02, 1);
    add_vec(0, 1, 1, 3, 1,   1, 6'h08, 6'h08, 0);
    add_vec(0, 1, 1, 5, 0,   1, 6'h20, 6'h28, 0);
    add_vec(1, 1, 1, 4, 0,   0, 6'h00, 6'h00, 0);
    add_vec(0, 1, 0, 0, 0,   0, 6'h00, 6'h00, 0);
    add_vec(0, 1, 1, 4, 0,   1, 6'h10, 6'h10, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset_b       = vecs[i].rst;
      if_b.enable   = vecs[i].en;
      if_b.in_valid = vecs[i].iv;
      if_b.encoded  = vecs[i].enc;
      if_b.clear    = vecs[i].clr;
      @(posedge clock);
      #1;
      check("b_ov",  i, 32'(if_b.out_valid), 32'(vecs[i].ov));
      check("b_dec", i, 32'(if_b.decoded),   32'(vecs[i].dec));
      check("b_st",  i, 32'(if_b.sticky),    32'(vecs[i].st));
`ifdef DECODER_RANGE_CHECK_EN
      check("b_rerr", i, 32'(if_b.range_err), 32'(vecs[i].rerr));
`endif
    end

    // reset state, then indices 0,1,2 back-to-back: results appear on the third edge
    a_cycle("a_rst", 1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    a_cycle("a_lat", 0, 1, 1, 0, 0, 0, 8'h00, 8'h00);
    a_cycle("a_lat", 0, 1, 1, 1, 0, 0, 8'h00, 8'h00);
    a_cycle("a_lat", 0, 1, 1, 2, 0, 1, 8'h01, 8'h01);
    a_cycle("a_lat", 0, 1, 0, 0, 0, 1, 8'h02, 8'h03);
    a_cycle("a_lat", 0, 1, 0, 0, 0, 1, 8'h04, 8'h07);
    a_cycle("a_lat", 0, 1, 0, 0, 0, 0, 8'h00, 8'h07);

    // clear coincident with a valid result for index 6, then clear alone
    a_cycle("a_clr", 0, 1, 1, 6, 0, 0, 8'h00, 8'h07);
    a_cycle("a_clr", 0, 1, 0, 0, 0, 0, 8'h00, 8'h07);
    a_cycle("a_clr", 0, 1, 0, 0, 1, 1, 8'h40, 8'h40);
    a_cycle("a_clr", 0, 1, 0, 0, 1, 0, 8'h00, 8'h00);

    // four-cycle stall mid-stream: outputs frozen, stream resumes 3,4,5,6 in order
    a_cycle("a_stall", 0, 1, 1, 3, 0, 0, 8'h00, 8'h00);
    a_cycle("a_stall", 0, 1, 1, 4, 0, 0, 8'h00, 8'h00);
    a_cycle("a_stall", 0, 1, 1, 5, 0, 1, 8'h08, 8'h08);
    for (int k = 0; k < 4; k++) a_cycle("a_stall", 0, 0, 1, 7, 0, 1, 8'h08, 8'h08);
    a_cycle("a_stall", 0, 1, 1, 6, 0, 1, 8'h10, 8'h18);
    a_cycle("a_stall", 0, 1, 0, 0, 0, 1, 8'h20, 8'h38);
    a_cycle("a_stall", 0, 1, 0, 0, 0, 1, 8'h40, 8'h78);
    a_cycle("a_stall", 0, 1, 0, 0, 0, 0, 8'h00, 8'h78);

    // reset with two entries in flight: nothing emerges until new input arrives
    a_cycle("a_mrst", 0, 1, 1, 1, 0, 0, 8'h00, 8'h78);
    a_cycle("a_mrst", 0, 1, 1, 2, 0, 0, 8'h00, 8'h78);
    a_cycle("a_mrst", 1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) a_cycle("a_mrst", 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    a_cycle("a_mrst", 0, 1, 1, 7, 0, 0, 8'h00, 8'h00);
    a_cycle("a_mrst", 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    a_cycle("a_mrst", 0, 1, 0, 0, 0, 1, 8'h80, 8'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
